ps_rr_arbiter: RTL
==================

Name: ps_rr_arbiter

Overview:
Round-robin arbiter that shares the single ps register bus of one rf_node between NUM_REQ requesters. Typical requesters are the AXI-lite ps adapter, an on-chip sequencer and a debug port.
- Serialises accesses, with one transaction outstanding at a time.
- Returns each response only to the requester that issued it.
- Generates an error response if the slave does not answer within TIMEOUT cycles.
- Sits between the requesters and the rf_node ps port.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_WIDTH, 4, register address width
DATA_WIDTH, 32, register data width
TIMEOUT, 255, maximum WAIT cycles before an error response (1..65535)

Ports:
clk  in  1  clock
rst  in  1  reset
m_req_valid  in  NUM_REQ  per-requester request valid
m_req_ready  out  NUM_REQ  per-requester request accepted (one-cycle pulse)
m_req_we  in  NUM_REQ  1 = write, 0 = read
m_req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice i
m_req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
m_rsp_valid  out  NUM_REQ  per-requester response pulse
m_rsp_err  out  1  error flag (timeout), qualified by m_rsp_valid
m_rsp_rdata  out  DATA_WIDTH  read data, qualified by m_rsp_valid
s_req_valid  out  1  request to slave
s_req_ready  in  1  slave accepts request
s_req_we  out  1  write enable to slave
s_req_addr  out  ADDR_WIDTH  address to slave
s_req_wdata  out  DATA_WIDTH  write data to slave
s_rsp_valid  in  1  slave response/ack (returned for both reads and writes)
s_rsp_rdata  in  DATA_WIDTH  slave read data
grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester
busy  out  1  high whenever state is not IDLE

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset values:
  - state is IDLE and the priority pointer is 0.
  - All outputs are 0: m_req_ready, m_rsp_valid, m_rsp_err, m_rsp_rdata, s_req_valid, s_req_we, s_req_addr, s_req_wdata, grant_id and busy.
- Reset mid-transaction aborts the transaction. No response is ever delivered for it, and s_req_valid drops at that edge.
- State IDLE:
  - If any m_req_valid bit is set, pick the winner as the first set bit at or above the pointer, wrapping modulo NUM_REQ.
  - Pulse m_req_ready[winner] combinationally in that same cycle.
  - Capture we/addr/wdata into registers and set grant_id = winner.
  - Set pointer = (winner+1) mod NUM_REQ, then go to ISSUE.
  - Requesters that did not win keep waiting. Their request must be held until their m_req_ready pulse.
- State ISSUE:
  - s_req_valid = 1, driven from the captured registers.
  - When s_req_ready = 1, go to WAIT and clear the timeout counter.
  - ISSUE has no timeout; it waits indefinitely for s_req_ready.
- State WAIT:
  - The counter increments each cycle.
  - If s_rsp_valid = 1, latch s_rsp_rdata, set err = 0 and go to RESP.
  - Otherwise, when the counter equals TIMEOUT-1, set rdata = 0, err = 1 and go to RESP.
  - If s_rsp_valid arrives in the same cycle the timeout hits, the real response wins.
- State RESP:
  - For exactly one cycle, drive m_rsp_valid[grant_id] = 1 with m_rsp_rdata and m_rsp_err. All other m_rsp_valid bits stay 0.
  - Return to IDLE. There is no response backpressure; requesters must sample during the pulse.
- s_rsp_valid is ignored in IDLE, ISSUE and RESP. A late response that arrives after a timeout is therefore dropped.
- Latency with a zero-wait slave (s_req_ready = 1, s_rsp_valid the cycle after ISSUE):
  - accept at T0, s_req_valid at T1, s_rsp_valid at T2, m_rsp_valid at T3.
  - The next grant can occur at T4, giving a 4-cycle minimum period per transaction.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,2,3,0,... A requester waits at most NUM_REQ-1 transactions before it is granted.
- m_rsp_rdata and m_rsp_err hold their last values outside RESP. s_req_* hold their values outside ISSUE, but s_req_valid is 0 there.

Decomposition:
- Package ps_arb_pkg:
  - state enum arb_state_e {IDLE, ISSUE, WAIT, RESP}.
  - function returning the id width (clog2, minimum 1).
  - typedef for the captured request struct {we, addr, wdata}, parameterised through localparams in the module.
- Sub-module rr_pick:
  - Purely combinational round-robin priority picker.
  - Inputs: req vector and pointer. Outputs: onehot grant, index and any_valid.
  - Reusable by other arbiters in the codebase.
- The FSM, capture registers and timeout counter stay in ps_rr_arbiter.

Test Plan:
1. Single read: requester 2 reads addr 0x3; slave acks after 1 cycle with 0xDEADBEEF. Expect m_req_ready[2] at T0, s_req_addr = 0x3 with s_req_we = 0, m_rsp_valid = 0b0100 at T3 with rdata 0xDEADBEEF and err = 0.
2. Contention: all 4 requesters write 0x10+i continuously. Expect the grant order 0,1,2,3,0,1 and s_req_wdata sequence 0x10,0x11,0x12,0x13,... Each m_rsp_valid pulse goes only to the granted requester.
3. Timeout: TIMEOUT = 8; slave never asserts s_rsp_valid. Expect the response exactly 8 WAIT cycles after the handshake, with err = 1 and rdata = 0. A later stray s_rsp_valid in IDLE is ignored, producing no pulse and no state change.
4. Backpressure: hold s_req_ready = 0 for 20 cycles. Expect s_req_valid stable and s_req_addr/wdata unchanged throughout, with no timeout. The handshake completes on the first cycle s_req_ready = 1.
5. Simultaneous events: s_rsp_valid = 1 with data 0x55 in the same cycle the counter reaches TIMEOUT-1. Expect err = 0 and rdata = 0x55.
6. Reset mid-operation: assert rst in WAIT. Expect at the next edge busy = 0, s_req_valid = 0, no m_rsp_valid pulse and pointer = 0. The next request from requester 3, with 1 also requesting, grants requester 1 first.

Source files
------------

// File: rtl/ps_arb_pkg.sv
// Shared types and helpers for the ps register-bus arbiter.
package ps_arb_pkg;

    // Arbiter transaction phases.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    // Timeout counter width; covers TIMEOUT values up to 65535.
    localparam int CNT_W = 16;

    // Width of a requester index, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping modulo N. Reusable by any arbiter.
module rr_pick
    import ps_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = id_width(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Scan N candidates starting at the pointer; the first hit wins.
    always_comb begin
        logic found;
        // NOTE: every output gets a default before the loop, so no path
        // leaves a value unassigned and no latch is inferred.
        found   = 1'b0;
        o_grant = '0;
        o_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && i_req[(int'(i_ptr) + i) % N]) begin
                found                            = 1'b1;
                o_grant[(int'(i_ptr) + i) % N]   = 1'b1;
                o_idx                            = IDX_W'((int'(i_ptr) + i) % N);
            end
        end
        o_any = found;
    end

endmodule

// File: rtl/ps_rr_arbiter.sv
// Round-robin arbiter sharing one rf_node ps register bus between
// NUM_REQ requesters; one transaction in flight, timeout error response.
module ps_rr_arbiter
    import ps_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255,
    localparam int ID_W      = id_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            m_req_valid,
    output logic [NUM_REQ-1:0]            m_req_ready,
    input  logic [NUM_REQ-1:0]            m_req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] m_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] m_req_wdata,
    output logic [NUM_REQ-1:0]            m_rsp_valid,
    output logic                          m_rsp_err,
    output logic [DATA_WIDTH-1:0]         m_rsp_rdata,
    output logic                          s_req_valid,
    input  logic                          s_req_ready,
    output logic                          s_req_we,
    output logic [ADDR_WIDTH-1:0]         s_req_addr,
    output logic [DATA_WIDTH-1:0]         s_req_wdata,
    input  logic                          s_rsp_valid,
    input  logic [DATA_WIDTH-1:0]         s_rsp_rdata,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy
);

    // Request captured from the winning requester at grant time.
    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    arb_state_e            r_state;
    arb_state_e            w_next_state;
    req_t                  r_req;
    logic [ID_W-1:0]       r_ptr;
    logic [ID_W-1:0]       r_grant_id;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;

    logic [NUM_REQ-1:0]    w_pick_onehot;
    logic [ID_W-1:0]       w_pick_idx;
    logic                  w_pick_any;
    logic                  w_accept;
    logic                  w_timeout;
    logic [ID_W-1:0]       w_ptr_next;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_pick (
        .i_req   (m_req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_pick_onehot),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    assign w_accept   = (r_state == IDLE) && w_pick_any && !rst;
    assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_ptr_next = (w_pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_pick_idx + 1'b1;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register samples pre-edge values regardless of block order.
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and state-derived handshake outputs.
    always_comb begin
        w_next_state = r_state;
        m_req_ready  = '0;
        m_rsp_valid  = '0;
        s_req_valid  = 1'b0;
        busy         = (r_state != IDLE);
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    m_req_ready  = w_pick_onehot;
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                s_req_valid = 1'b1;
                if (s_req_ready) w_next_state = WAIT;
            end
            WAIT: begin
                if (s_rsp_valid || w_timeout) w_next_state = RESP;
            end
            RESP: begin
                m_rsp_valid[r_grant_id] = 1'b1;
                w_next_state            = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Capture registers, round-robin pointer, timeout counter, response data.
    always_ff @(posedge clk) begin
        // NOTE: the data registers are reset as well because they drive
        // outputs directly and those must read 0 straight out of reset.
        if (rst) begin
            r_req       <= '0;
            r_ptr       <= '0;
            r_grant_id  <= '0;
            r_cnt       <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_req.we    <= m_req_we[w_pick_idx];
                r_req.addr  <= m_req_addr[int'(w_pick_idx) * ADDR_WIDTH +: ADDR_WIDTH];
                r_req.wdata <= m_req_wdata[int'(w_pick_idx) * DATA_WIDTH +: DATA_WIDTH];
                r_grant_id  <= w_pick_idx;
                r_ptr       <= w_ptr_next;
            end
            if (r_state == ISSUE && s_req_ready) begin
                r_cnt <= '0;
            end
            if (r_state == WAIT) begin
                if (s_rsp_valid) begin
                    // A real response beats a simultaneous timeout.
                    r_rsp_rdata <= s_rsp_rdata;
                    r_rsp_err   <= 1'b0;
                end else if (w_timeout) begin
                    r_rsp_rdata <= '0;
                    r_rsp_err   <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign s_req_we    = r_req.we;
    assign s_req_addr  = r_req.addr;
    assign s_req_wdata = r_req.wdata;
    assign m_rsp_rdata = r_rsp_rdata;
    assign m_rsp_err   = r_rsp_err;
    assign grant_id    = r_grant_id;

endmodule
